// File: rtl/alu_sched.sv
// Round-robin scheduler that time-shares one 8-bit ALU between two clients.
// The winner's operands are held for a per-opcode latency, then the result is returned.
module alu_sched #(
  parameter int LAT_FAST = 1,
  parameter int LAT_DIV  = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] res_y,
  output logic [7:0] res_z,
  output logic       res_o,
  output logic       res_c,
  output logic       busy,
  output logic [1:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_y,
  input  logic [7:0] alu_z,
  input  logic       alu_o,
  input  logic       alu_c
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     state_q;
  logic [5:0] cnt_q;
  logic       last_q;
  logic       gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic [7:0] res_y_q, res_z_q;
  logic       res_o_q, res_c_q;
  logic [1:0] alu_op_q;
  logic [7:0] alu_a_q, alu_b_q;

  logic       win_any_d;
  logic       win_sel_d;
  logic [1:0] win_op_d;
  logic [7:0] win_a_d, win_b_d;
  logic [5:0] cnt_d;

  // On a tie the client that was not granted last wins.
  always_comb begin
    win_any_d = req0 | req1;
    win_sel_d = (req0 && req1) ? ~last_q : req1;
    win_op_d  = win_sel_d ? op1 : op0;
    win_a_d   = win_sel_d ? a1  : a0;
    win_b_d   = win_sel_d ? b1  : b0;
    cnt_d     = (win_op_d == 2'b11) ? 6'(LAT_DIV) : 6'(LAT_FAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      res_y_q  <= '0;
      res_z_q  <= '0;
      res_o_q  <= 1'b0;
      res_c_q  <= 1'b0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (state_q == IDLE) begin
        if (win_any_d) begin
          alu_op_q <= win_op_d;
          alu_a_q  <= win_a_d;
          alu_b_q  <= win_b_d;
          gnt0_q   <= ~win_sel_d;
          gnt1_q   <= win_sel_d;
          last_q   <= win_sel_d;
          cnt_q    <= cnt_d;
          busy_q   <= 1'b1;
          state_q  <= EXEC;
        end
      end else begin
        cnt_q <= cnt_q - 6'd1;
        // last_q still names the client that owns the operation in flight.
        if (cnt_q <= 6'd1) begin
          res_y_q <= alu_y;
          res_z_q <= alu_z;
          res_o_q <= alu_o;
          res_c_q <= alu_c;
          done0_q <= ~last_q;
          done1_q <= last_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign busy       = busy_q;
  assign res_y      = res_y_q;
  assign res_z      = res_z_q;
  assign res_o      = res_o_q;
  assign res_c      = res_c_q;
  assign alu_opcode = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed plus randomized bench for alu_sched with an adder/xor ALU stub.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_alu_sched;
  localparam int LAT_FAST = 1;
  localparam int LAT_DIV  = 26;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] res_y, res_z;
  logic       res_o, res_c, busy;
  logic [1:0] alu_opcode;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_y, alu_z;
  logic       alu_o, alu_c;

  int checks = 0;
  int errors = 0;
  int last_m = 1;

  alu_sched #(.LAT_FAST(LAT_FAST), .LAT_DIV(LAT_DIV)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res_y(res_y), .res_z(res_z), .res_o(res_o), .res_c(res_c),
    .busy(busy), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_z(alu_z), .alu_o(alu_o), .alu_c(alu_c)
  );

  always #5 clock = ~clock;

  // ALU stub
  always_comb begin
    {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
    alu_z = alu_a ^ alu_b;
    alu_o = alu_opcode[1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulses"}, {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res"}, {14'd0, res_y, res_z, res_o, res_c}, 32'd0);
    chk({tag, "_alu"}, {14'd0, alu_opcode, alu_a, alu_b}, 32'd0);
  endtask

  // One operation from the expected winner: returns how many cycles were waited for its grant.
  task automatic do_op(input int who, input bit drop, input int raise0_at, output int waits);
    logic [1:0] eop;
    logic [7:0] ea, eb;
    logic [8:0] sum;
    int lat;
    eop = (who == 1) ? op1 : op0;
    ea  = (who == 1) ? a1 : a0;
    eb  = (who == 1) ? b1 : b0;
    sum = {1'b0, ea} + {1'b0, eb};
    lat = (eop == 2'b11) ? LAT_DIV : LAT_FAST;
    waits = 0;
    do begin
      @(negedge clock);
      waits++;
    end while (!(gnt0 || gnt1) && waits < 200);
    chk("gnt_seen", gnt0 | gnt1, 1);
    chk("gnt0", gnt0, (who == 0) ? 1 : 0);
    chk("gnt1", gnt1, (who == 1) ? 1 : 0);
    chk("busy_at_gnt", busy, 1);
    chk("alu_in", {14'd0, alu_opcode, alu_a, alu_b}, {14'd0, eop, ea, eb});
    last_m = who;
    if (drop) begin
      if (who == 0) req0 = 1'b0;
      else req1 = 1'b0;
    end
    for (int n = 1; n <= lat; n++) begin
      @(negedge clock);
      if (n == raise0_at) req0 = 1'b1;
      chk("alu_stable", {14'd0, alu_opcode, alu_a, alu_b}, {14'd0, eop, ea, eb});
      if (n < lat) begin
        chk("exec_busy", busy, 1);
        chk("exec_pulses", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
      end else begin
        chk("done_pulses", {28'd0, gnt0, gnt1, done0, done1},
            (who == 0) ? 32'd2 : 32'd1);
        chk("done_busy", busy, 0);
        chk("res_y", res_y, sum[7:0]);
        chk("res_z", res_z, ea ^ eb);
        chk("res_c", res_c, sum[8]);
        chk("res_o", res_o, eop[1]);
      end
    end
    $display("op client=%0d opcode=%0d a=%02h b=%02h lat=%0d res_y=%02h res_c=%0b",
             who, eop, ea, eb, lat, res_y, res_c);
  endtask

  initial begin
    int w;
    int winner;
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    op0 = 2'b00; a0 = 8'h13; b0 = 8'h2C;
    op1 = 2'b01; a1 = 8'h40; b1 = 8'h05;

    // Reset held three cycles with both clients requesting
    repeat (3) begin
      @(negedge clock);
      chk_all_zero("reset");
    end
    reset = 1'b0;

    // First tie after reset goes to client 0, then strict alternation
    do_op(0, 1'b0, -1, w); chk("first_gnt_wait", w, 1);
    do_op(1, 1'b0, -1, w); chk("alt_wait1", w, 1);
    do_op(0, 1'b0, -1, w); chk("alt_wait2", w, 1);
    do_op(1, 1'b1, -1, w); chk("alt_wait3", w, 1);
    req0 = 1'b0;
    repeat (3) @(negedge clock);

    // Single add
    op0 = 2'b00; a0 = 8'h13; b0 = 8'h2C; req0 = 1'b1;
    do_op(0, 1'b1, -1, w);
    chk("add_y", res_y, 8'h3F);
    chk("add_z", res_z, 8'h3F);
    chk("add_c", res_c, 0);

    // Divide latency, client 0 arrives mid-operation
    op1 = 2'b11; a1 = 8'h7F; b1 = 8'h08;
    op0 = 2'b10; a0 = 8'h21; b0 = 8'h03;
    @(negedge clock); req1 = 1'b1;
    do_op(1, 1'b1, 5, w);
    do_op(0, 1'b1, -1, w); chk("gnt0_after_div", w, 1);

    // Reset ten cycles into a divide
    @(negedge clock); req1 = 1'b1;
    w = 0;
    do begin @(negedge clock); w++; end while (!gnt1 && w < 50);
    chk("div2_gnt1", gnt1, 1);
    req1 = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("mid_reset");
    reset = 1'b0;
    last_m = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      chk("no_done_after_abort", {30'd0, done1, busy}, 32'd0);
    end
    op0 = 2'b00; a0 = 8'h55; b0 = 8'h22; req0 = 1'b1;
    do_op(0, 1'b1, -1, w);

    // Carry out, result held while idle
    op0 = 2'b00; a0 = 8'hFF; b0 = 8'h01; req0 = 1'b1;
    do_op(0, 1'b1, -1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("carry_hold", {22'd0, res_y, res_c, done0}, {22'd0, 8'h00, 1'b1, 1'b0});
    end

    // Randomized traffic against the round-robin rule
    for (int it = 0; it < 25; it++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        op0 = 2'($urandom); a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        op1 = 2'($urandom); a1 = 8'($urandom); b1 = 8'($urandom); req1 = 1'b1;
      end
      if (!req0 && !req1) begin
        op0 = 2'($urandom); a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
      end
      if (req0 && req1) winner = (last_m == 0) ? 1 : 0;
      else winner = req1 ? 1 : 0;
      do_op(winner, 1'b1, -1, w);
      chk("rand_wait", w, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
